// File: rtl/font_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : font_rom_arbiter_if
//  Description : Bundle of request, grant, font-ROM and response signals
//                shared by the font ROM arbiter and its surroundings.
//  Revision    : 1.0 - initial release
// ============================================================================
interface font_rom_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 3
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            gnt;
  logic [ADDR_WIDTH-1:0]         rom_addr;
  logic [DATA_WIDTH-1:0]         rom_dout;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          busy;

  // Environment side: digit renderers plus the font ROM itself.
  modport master (
    output req, req_lock, req_addr, rom_dout,
    input  gnt, rom_addr, rsp_valid, rsp_data, busy
  );

  // Arbiter side.
  modport slave (
    input  req, req_lock, req_addr, rom_dout,
    output gnt, rom_addr, rsp_valid, rsp_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/font_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : font_rom_arbiter
//  Description : Round-robin arbiter sharing one synchronous font ROM between
//                the hours/minutes/seconds digit renderers, with lockable
//                bursts for a full glyph row.
//  Revision    : 1.0 - initial release
// ============================================================================
module font_rom_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  font_rom_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  idx_t                  ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_w;

  logic                  pick_found;
  idx_t                  pick_idx;
  idx_t                  pick_cand;
  idx_t                  owner_idx;
  logic                  owner_hold;
  logic                  grant_new;

  // Modulo-NUM_REQ increment of a requester index.
  function automatic idx_t wrap_inc(input idx_t v);
    if (v == idx_t'(NUM_REQ - 1)) return '0;
    return v + idx_t'(1);
  endfunction

  // Extract one requester's address from the flattened address bus.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(
    input logic [NUM_REQ*ADDR_WIDTH-1:0] flat,
    input idx_t                          idx
  );
    return flat[idx*ADDR_WIDTH +: ADDR_WIDTH];
  endfunction

  // Round-robin search: first requester at or after ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    pick_cand  = ptr_q;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!pick_found && bus.req[pick_cand]) begin
        pick_found = 1'b1;
        pick_idx   = pick_cand;
      end
      pick_cand = wrap_inc(pick_cand);
    end
  end

  // Decode the current owner index from the one-hot grant.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) owner_idx = idx_t'(i);
    end
  end

  // Next-state logic: keep a locked owner, otherwise arbitrate afresh.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = '0;
    addr_d     = addr_q;
    grant_new  = 1'b0;
    owner_hold = gnt_q[owner_idx] & bus.req[owner_idx] & bus.req_lock[owner_idx];

    case (state_q)
      S_IDLE: begin
        if (pick_found) grant_new = 1'b1;
      end
      S_GRANT, S_LOCK: begin
        if (owner_hold) begin
          // Burst continues: one ROM read per cycle, pointer frozen.
          state_d = S_LOCK;
          gnt_d   = gnt_q;
          addr_d  = addr_of(bus.req_addr, owner_idx);
        end else if (pick_found) begin
          grant_new = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (grant_new) begin
      state_d         = S_GRANT;
      gnt_d[pick_idx] = 1'b1;
      addr_d          = addr_of(bus.req_addr, pick_idx);
      ptr_d           = wrap_inc(pick_idx);
    end
  end

  // State, pointer, grant/address registers and the response strobe pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= gnt_q;
    end
  end

  // ROM data arrives one cycle after the address, aligned with rsp_valid.
  assign rsp_data_w    = bus.rom_dout;

  assign bus.gnt       = gnt_q;
  assign bus.rom_addr  = addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_w;
  assign bus.busy      = |gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_font_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_font_rom_arbiter
//  Description : Vector-table bench for font_rom_arbiter with a response
//                scoreboard and a model of the synchronous font ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_font_rom_arbiter;

  typedef struct {
    logic [2:0] req;
    logic [2:0] lock;
    logic [5:0] a0;
    logic [5:0] a1;
    logic [5:0] a2;
    logic [2:0] gnt;
    logic [5:0] addr;
  } vec_t;

  typedef struct {
    logic [2:0] v;
    logic [2:0] d;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  vec_t tbl[$];
  rsp_t sb[$];

  font_rom_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(6), .DATA_WIDTH(3)) bus ();

  font_rom_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(6), .DATA_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Font ROM contents: a simple fold of the address bits.
  function automatic logic [2:0] rom_f(input logic [5:0] a);
    return a[2:0] ^ a[5:3];
  endfunction

  // Synchronous font ROM: data valid one cycle after the address.
  always @(posedge clk) bus.rom_dout <= rom_f(bus.rom_addr);

  function automatic vec_t mk(input logic [2:0] r, input logic [2:0] l,
                              input logic [5:0] a0, input logic [5:0] a1,
                              input logic [5:0] a2, input logic [2:0] g,
                              input logic [5:0] ad);
    vec_t v;
    v.req = r; v.lock = l; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.gnt = g; v.addr = ad;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},  32'(bus.gnt),       32'd0);
    check({tag, "_rspv"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_addr"}, 32'(bus.rom_addr),  32'd0);
    check({tag, "_busy"}, 32'(bus.busy),      32'd0);
  endtask

  // Drive one vector, then check grant side and the scoreboarded response.
  task automatic apply(input vec_t v, input string tag);
    rsp_t e;
    bus.req      = v.req;
    bus.req_lock = v.lock;
    bus.req_addr = {v.a2, v.a1, v.a0};
    @(posedge clk);
    #1;
    check({tag, "_gnt"},  32'(bus.gnt),      32'(v.gnt));
    check({tag, "_addr"}, 32'(bus.rom_addr), 32'(v.addr));
    check({tag, "_busy"}, 32'(bus.busy),     32'(|v.gnt));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_rspv"}, 32'(bus.rsp_valid), 32'(e.v));
      if (e.v != 3'b000) check({tag, "_rspd"}, 32'(bus.rsp_data), 32'(e.d));
    end
    e.v = v.gnt;
    e.d = rom_f(v.addr);
    sb.push_back(e);
  endtask

  initial begin
    // Round-robin over all three, idle gap, single pulse, locked burst,
    // single persistent requester, pointer wrap, final idle.
    for (int i = 0; i < 2; i++) begin
      tbl.push_back(mk(3'b111, 3'b000, 6'd5, 6'd23, 6'd42, 3'b001, 6'd5));
      tbl.push_back(mk(3'b111, 3'b000, 6'd5, 6'd23, 6'd42, 3'b010, 6'd23));
      tbl.push_back(mk(3'b111, 3'b000, 6'd5, 6'd23, 6'd42, 3'b100, 6'd42));
    end
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(3'b000, 3'b000, 6'd5, 6'd23, 6'd42, 3'b000, 6'd42));
    tbl.push_back(mk(3'b010, 3'b000, 6'd11, 6'd23, 6'd33, 3'b010, 6'd23));
    tbl.push_back(mk(3'b000, 3'b000, 6'd11, 6'd60, 6'd33, 3'b000, 6'd23));
    tbl.push_back(mk(3'b000, 3'b000, 6'd11, 6'd60, 6'd33, 3'b000, 6'd23));
    tbl.push_back(mk(3'b101, 3'b100, 6'd5, 6'd23, 6'd42, 3'b100, 6'd42));
    tbl.push_back(mk(3'b101, 3'b100, 6'd5, 6'd23, 6'd43, 3'b100, 6'd43));
    tbl.push_back(mk(3'b101, 3'b100, 6'd5, 6'd23, 6'd44, 3'b100, 6'd44));
    tbl.push_back(mk(3'b101, 3'b100, 6'd5, 6'd23, 6'd45, 3'b100, 6'd45));
    tbl.push_back(mk(3'b001, 3'b000, 6'd5, 6'd23, 6'd45, 3'b001, 6'd5));
    tbl.push_back(mk(3'b000, 3'b000, 6'd5, 6'd23, 6'd45, 3'b000, 6'd5));
    tbl.push_back(mk(3'b001, 3'b000, 6'd7, 6'd23, 6'd42, 3'b001, 6'd7));
    tbl.push_back(mk(3'b001, 3'b000, 6'd8, 6'd23, 6'd42, 3'b001, 6'd8));
    tbl.push_back(mk(3'b001, 3'b000, 6'd9, 6'd23, 6'd42, 3'b001, 6'd9));
    tbl.push_back(mk(3'b110, 3'b000, 6'd5, 6'd23, 6'd42, 3'b010, 6'd23));
    tbl.push_back(mk(3'b111, 3'b000, 6'd5, 6'd23, 6'd42, 3'b100, 6'd42));
    tbl.push_back(mk(3'b111, 3'b000, 6'd5, 6'd23, 6'd42, 3'b001, 6'd5));
    tbl.push_back(mk(3'b000, 3'b000, 6'd5, 6'd23, 6'd42, 3'b000, 6'd5));

    bus.req      = '0;
    bus.req_lock = '0;
    bus.req_addr = '0;

    // Reset is asynchronous: outputs must clear before any clock edge.
    #1 rst = 1'b1;
    #1;
    check_idle_outputs("rst_noclk");
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("rst_clk");
    rst = 1'b0;
    sb.delete();
    sb.push_back('{3'b000, 3'b000});

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("v%0d", i));

    // Locked burst on requester 1, then reset between clock edges.
    apply(mk(3'b010, 3'b010, 6'd5, 6'd50, 6'd42, 3'b010, 6'd50), "lk0");
    apply(mk(3'b010, 3'b010, 6'd5, 6'd51, 6'd42, 3'b010, 6'd51), "lk1");
    #3 rst = 1'b1;
    #1;
    check_idle_outputs("arst");
    @(posedge clk);
    #1;
    check_idle_outputs("arst_hold");
    rst = 1'b0;
    sb.delete();
    sb.push_back('{3'b000, 3'b000});
    // Pointer must restart at 0, so requester 1 wins over requester 2.
    apply(mk(3'b110, 3'b000, 6'd5, 6'd17, 6'd42, 3'b010, 6'd17), "post0");
    apply(mk(3'b000, 3'b000, 6'd5, 6'd17, 6'd42, 3'b000, 6'd17), "post1");
    apply(mk(3'b000, 3'b000, 6'd5, 6'd17, 6'd42, 3'b000, 6'd17), "post2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
